// File: rtl/vga_fb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_fetch_ctrl
//  Description : Avalon-MM burst-read scheduler streaming one framebuffer per
//                frame from the DDR3 EMIF into the VGA pixel FIFO. Bursts are
//                issued only when the FIFO can absorb every beat in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_fetch_ctrl #(
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 32,
    parameter int BURST_LEN   = 16,
    parameter int FIFO_DEPTH  = 256,
    parameter int FRAME_BEATS = 76800
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [ADDR_W-1:0]             fb_base,
    input  logic                          mem_ready,
    input  logic                          frame_start,
    output logic [ADDR_W-1:0]             avm_address,
    output logic [$clog2(BURST_LEN):0]    avm_burstcount,
    output logic                          avm_read,
    input  logic                          avm_waitrequest,
    input  logic                          avm_readdatavalid,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_usedw,
    output logic                          fifo_wr,
    output logic                          fifo_clr,
    output logic                          frame_done,
    output logic [15:0]                   late_cnt
);

    localparam int BC_W  = $clog2(BURST_LEN) + 1;
    localparam int OUT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REM_W = $clog2(FRAME_BEATS + 1);
    localparam int SUM_W = OUT_W + 2;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SYNC        = 3'd1,
        S_ISSUE       = 3'd2,
        S_CMD         = 3'd3,
        S_DONE_WAIT   = 3'd4,
        S_IDLE_ACTIVE = 3'd5,
        S_DRAIN       = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [REM_W-1:0]    remaining_q, remaining_d;
    logic [OUT_W-1:0]    outstanding_q, outstanding_d;
    logic [15:0]         late_q, late_d;
    logic                restart_q, restart_d;     // frame_start seen while a command was stalled
    logic                read_q, read_d;
    logic [ADDR_W-1:0]   avm_addr_q, avm_addr_d;
    logic [BC_W-1:0]     bc_q, bc_d;

    logic                w_run;
    logic                w_acc;
    logic                w_discard;
    logic                w_fits;
    logic [BC_W-1:0]     w_bc;
    logic [OUT_W-1:0]    w_out_inc;
    logic [15:0]         w_late_inc;

    assign w_run      = enable & mem_ready;
    assign w_acc      = read_q & ~avm_waitrequest;
    assign w_bc       = (32'(remaining_q) >= 32'(BURST_LEN)) ? BC_W'(BURST_LEN) : BC_W'(remaining_q);
    assign w_fits     = (SUM_W'(fifo_usedw) + SUM_W'(outstanding_q) + SUM_W'(w_bc)) <= SUM_W'(FIFO_DEPTH);
    assign w_out_inc  = w_acc ? OUT_W'(bc_q) : '0;
    assign w_late_inc = (late_q == 16'hFFFF) ? late_q : late_q + 16'd1;

    assign avm_address    = avm_addr_q;
    assign avm_burstcount = bc_q;
    assign avm_read       = read_q;
    assign late_cnt       = late_q;
    // Returned beats go straight to the FIFO unless the frame is being restarted or aborted.
    assign fifo_wr        = avm_readdatavalid & ~w_discard;

    // State and datapath registers; every counter clears on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            late_q        <= '0;
            restart_q     <= 1'b0;
            read_q        <= 1'b0;
            avm_addr_q    <= '0;
            bc_q          <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            late_q        <= late_d;
            restart_q     <= restart_d;
            read_q        <= read_d;
            avm_addr_q    <= avm_addr_d;
            bc_q          <= bc_d;
        end
    end

    // Next-state, command issue, credit accounting and one-cycle strobes.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q + w_out_inc - OUT_W'(avm_readdatavalid);
        late_d        = late_q;
        restart_d     = restart_q;
        read_d        = read_q;
        avm_addr_d    = avm_addr_q;
        bc_d          = bc_q;
        fifo_clr      = 1'b0;
        frame_done    = 1'b0;
        w_discard     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_run && frame_start) state_d = S_SYNC;
            end
            S_SYNC: begin
                // Beats from the abandoned frame are dropped until none remain in flight.
                w_discard = 1'b1;
                if (!w_run) begin
                    state_d = S_DRAIN;
                end else if (outstanding_q == '0) begin
                    fifo_clr    = 1'b1;
                    addr_d      = fb_base;
                    remaining_d = REM_W'(FRAME_BEATS);
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!w_run) begin
                    state_d = S_DRAIN;
                end else if (frame_start) begin
                    late_d  = w_late_inc;
                    state_d = S_SYNC;
                end else if (remaining_q == '0) begin
                    state_d = S_DONE_WAIT;
                end else if (w_fits) begin
                    read_d     = 1'b1;
                    avm_addr_d = addr_q;
                    bc_d       = w_bc;
                    state_d    = S_CMD;
                end
            end
            S_CMD: begin
                // A posted command is held until accepted; it is never withdrawn.
                if (frame_start) late_d = w_late_inc;
                if (w_acc) begin
                    read_d      = 1'b0;
                    addr_d      = addr_q + ADDR_W'(bc_q) * ADDR_W'(DATA_W / 8);
                    remaining_d = remaining_q - REM_W'(bc_q);
                    restart_d   = 1'b0;
                    if (restart_q || frame_start) state_d = S_SYNC;
                    else if (!w_run)              state_d = S_DRAIN;
                    else                          state_d = S_ISSUE;
                end else if (frame_start) begin
                    restart_d = 1'b1;
                end
            end
            S_DONE_WAIT: begin
                if (!w_run) begin
                    state_d = S_DRAIN;
                end else if (frame_start) begin
                    late_d  = w_late_inc;
                    state_d = S_SYNC;
                end else if (outstanding_q == '0) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE_ACTIVE;
                end
            end
            S_IDLE_ACTIVE: begin
                if (!w_run)           state_d = S_IDLE;
                else if (frame_start) state_d = S_SYNC;
            end
            S_DRAIN: begin
                // Fetch stopped: let in-flight beats land without touching the FIFO.
                w_discard = 1'b1;
                if (outstanding_q == '0) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
